mio_uart_tx: RTL

- Memory-mapped UART transmitter peripheral and bus responder on the MIO bus.
- The CPU initiates word writes and reads; the bus decoder supplies a write strobe plus the decoded register select.
- The block buffers bytes in a small FIFO and serialises them as 8N1 frames, LSB first, on a single TX line.
- It runs on the IO clock, the same inverted CPU clock used by the other MIO peripherals.

---
 rtl/mio_uart_tx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mio_uart_tx.sv
// mio_uart_tx: MIO bus UART transmitter.
// Bytes written to DATA are queued in a small FIFO and sent as 8N1 frames,
// LSB first, with a per-frame baud divisor latched at the start bit.
module mio_uart_tx #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd868
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        EN,
   input  logic [1:0]  addr,
   input  logic [31:0] P_Data,
   output logic [31:0] rdata,
   output logic        tx,
   output logic        tx_busy,
   output logic        fifo_full,
   output logic        irq
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] count;
   logic          overflow;
   logic [15:0]   div, act_div, baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   state_t        state;

   logic empty, full, push_req, push, pop, baud_end;
   logic [3:0] cnt4;
   logic unused_pdata;

   assign empty     = (count == '0);
   assign full      = (count == CW'(FIFO_DEPTH));
   assign baud_end  = (baud_cnt == act_div - 16'd1);
   // Head is consumed either when idle or exactly at the end of a stop bit,
   // which gives back-to-back frames with no idle cycle in between.
   assign pop       = !empty && ((state == IDLE) || (state == STOP && baud_end));
   assign push_req  = EN && (addr == 2'd0);
   assign push      = push_req && (!full || pop);
   assign cnt4      = 4'(count);
   assign fifo_full = full;
   assign irq       = empty && !tx_busy;
   assign unused_pdata = ^P_Data[31:16];

   // Register read mux, combinational on addr.
   always_comb begin
      rdata = 32'h0;
      case (addr)
         2'd1:    rdata = {20'b0, cnt4, 4'b0, overflow, empty, full, tx_busy};
         2'd2:    rdata = {16'b0, div};
         default: rdata = 32'h0;
      endcase
   end

   // FIFO storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= P_Data[7:0];
   end

   // FIFO pointers, occupancy, sticky overflow and the divisor register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
         div      <= DIV_RESET;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push_req && full && !pop)
            overflow <= 1'b1;
         else if (EN && addr == 2'd1)
            overflow <= 1'b0;
         if (EN && addr == 2'd2)
            div <= (P_Data[15:0] == 16'd0) ? 16'd1 : P_Data[15:0];
      end
   end

   // Frame sequencer: tx and tx_busy are registered here only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         act_div  <= DIV_RESET;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  shreg    <= mem[rptr];
                  act_div  <= div;
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  tx       <= 1'b0;
                  tx_busy  <= 1'b1;
                  state    <= START;
               end
            end
            START: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  tx       <= shreg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            DATA: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shreg[bit_idx + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            STOP: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     shreg   <= mem[rptr];
                     act_div <= div;
                     bit_idx <= '0;
                     tx      <= 1'b0;
                     state   <= START;
                  end else begin
                     tx_busy <= 1'b0;
                     state   <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
